// File: rtl/speaker_arbiter_pkg.sv
// Shared state type, source index map and width helpers for the speaker arbiter.
package spk_arb_pkg;

   typedef enum logic [1:0] {IDLE, RING, GAP} arb_state_t;

   localparam int IDX_CD   = 0;
   localparam int IDX_ALR0 = 1;
   localparam int IDX_ALR1 = 2;
   localparam int IDX_ALR2 = 3;
   localparam int IDX_ALR3 = 4;
   localparam int IDX_HOUR = 5;

   // Counter width able to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/speaker_arbiter_if.sv
// Source-side request/tone bundle and arbiter results shared with the top level.
interface speaker_arbiter_if #(
   parameter int N_REQ = 6
);
   import spk_arb_pkg::*;

   localparam int IW = idx_width(N_REQ);

   logic             tick;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] audio;
   logic             dismiss;
   logic             mute_all;
   logic             speaker;
   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    active_idx;
   logic             busy;
   logic [N_REQ-1:0] muted;

   modport master (
      output tick, req, audio, dismiss, mute_all,
      input  speaker, grant, active_idx, busy, muted
   );

   modport slave (
      input  tick, req, audio, dismiss, mute_all,
      output speaker, grant, active_idx, busy, muted
   );

endinterface

// File: rtl/speaker_arbiter_prio_pick.sv
// Lowest-index-first finder: one-hot of the first set bit, its index and a valid flag.
module prio_pick
   import spk_arb_pkg::*;
#(
   parameter int N  = 6,
   parameter int IW = idx_width(N)
)(
   input  logic [N-1:0]  vec,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scanning downward lets the lowest set index overwrite any higher one.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IW'(i);
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/speaker_arbiter.sv
// Fixed-priority owner of the speaker pin: grants one sound source at a time with
// minimum hold, dismiss, ring timeout and a forced silent gap between owners.
module speaker_arbiter
   import spk_arb_pkg::*;
#(
   parameter int N_REQ    = 6,
   parameter int MIN_HOLD = 2,
   parameter int MAX_RING = 60,
   parameter int GAP_CYC  = 1000
)(
   input logic              clk,
   input logic              rst,
   speaker_arbiter_if.slave bus
);

   localparam int IW = idx_width(N_REQ);
   localparam int RW = cnt_width(MAX_RING);
   localparam int HW = cnt_width(MIN_HOLD);
   localparam int GW = cnt_width(GAP_CYC);

   localparam logic [RW-1:0] RING_SAT  = RW'(MAX_RING);
   localparam logic [RW-1:0] RING_LAST = RW'(MAX_RING - 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(MIN_HOLD);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

   arb_state_t       state, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] muted_q, muted_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             speaker_q, speaker_d;
   logic             busy_q, busy_d;
   logic [RW-1:0]    ring_cnt, ring_d;
   logic [HW-1:0]    hold_cnt, hold_d;
   logic [GW-1:0]    gap_cnt, gap_d;

   logic [N_REQ-1:0] eligible, higher_mask;
   logic [N_REQ-1:0] win_oh, next_oh, pre_oh_unused;
   logic [IW-1:0]    win_idx, next_idx, pre_idx_unused;
   logic             win_valid, pre_valid;
   logic             req_held, timeout, set_mute;

   assign eligible = bus.req & ~muted_q;
   assign req_held = |(bus.req & grant_q);
   assign timeout  = bus.tick && (ring_cnt == RING_LAST);

   always_comb begin
      higher_mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         higher_mask[i] = (IW'(i) < idx_q);
      end
   end

   prio_pick #(.N(N_REQ), .IW(IW)) u_win (
      .vec    (eligible),
      .onehot (win_oh),
      .idx    (win_idx),
      .valid  (win_valid)
   );

   prio_pick #(.N(N_REQ), .IW(IW)) u_pre (
      .vec    (eligible & higher_mask),
      .onehot (pre_oh_unused),
      .idx    (pre_idx_unused),
      .valid  (pre_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         grant_q   <= '0;
         muted_q   <= '0;
         idx_q     <= '0;
         speaker_q <= 1'b0;
         busy_q    <= 1'b0;
         ring_cnt  <= '0;
         hold_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         state     <= state_d;
         grant_q   <= grant_d;
         muted_q   <= muted_d;
         idx_q     <= idx_d;
         speaker_q <= speaker_d;
         busy_q    <= busy_d;
         ring_cnt  <= ring_d;
         hold_cnt  <= hold_d;
         gap_cnt   <= gap_d;
      end
   end

   // RING exits are ranked: request drop, dismiss, timeout, then preemption.
   always_comb begin
      state_d  = state;
      ring_d   = ring_cnt;
      hold_d   = hold_cnt;
      gap_d    = gap_cnt;
      set_mute = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid) begin
               state_d = RING;
               ring_d  = '0;
               hold_d  = '0;
            end
         end
         RING: begin
            if (!req_held) begin
               state_d = GAP;
            end else if (bus.dismiss || timeout) begin
               state_d  = GAP;
               set_mute = 1'b1;
            end else if (pre_valid && (hold_cnt >= HOLD_SAT)) begin
               state_d = GAP;
            end else if (bus.tick) begin
               if (ring_cnt != RING_SAT) ring_d = ring_cnt + 1'b1;
               if (hold_cnt != HOLD_SAT) hold_d = hold_cnt + 1'b1;
            end
            if (state_d == GAP) gap_d = '0;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_d = IDLE;
            else                     gap_d   = gap_cnt + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // A source only keeps its mute bit while it keeps requesting.
   always_comb begin
      next_oh   = (state == IDLE) ? win_oh  : grant_q;
      next_idx  = (state == IDLE) ? win_idx : idx_q;
      grant_d   = '0;
      idx_d     = '0;
      speaker_d = 1'b0;
      if (state_d == RING) begin
         grant_d   = next_oh;
         idx_d     = next_idx;
         speaker_d = (|(bus.audio & next_oh)) & ~bus.mute_all;
      end
      busy_d  = (state_d != IDLE);
      muted_d = bus.req & (muted_q | (set_mute ? grant_q : '0));
   end

   assign bus.speaker    = speaker_q;
   assign bus.grant      = grant_q;
   assign bus.active_idx = idx_q;
   assign bus.busy       = busy_q;
   assign bus.muted      = muted_q;

endmodule

// File: tb/tb_speaker_arbiter.sv
// Bench for speaker_arbiter: directed scenarios with literal checks plus a per-cycle behavioural model.
module tb_speaker_arbiter;

   localparam int N_REQ    = 6;
   localparam int MIN_HOLD = 2;
   localparam int MAX_RING = 5;
   localparam int GAP_CYC  = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [5:0] audio_prev = '0;

   speaker_arbiter_if #(.N_REQ(N_REQ)) bus ();

   speaker_arbiter #(
      .N_REQ    (N_REQ),
      .MIN_HOLD (MIN_HOLD),
      .MAX_RING (MAX_RING),
      .GAP_CYC  (GAP_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Model view: who owns the speaker, how many ticks it has rung, how long silence has lasted.
   typedef struct {
      int         mode;
      int         cur;
      int         ticks;
      int         gap;
      logic [5:0] muted;
      logic       spk;
   } model_t;

   model_t m;

   function automatic model_t modelReset();
      model_t r;
      r.mode = 0; r.cur = 0; r.ticks = 0; r.gap = 0; r.muted = '0; r.spk = 1'b0;
      return r;
   endfunction

   function automatic model_t modelNext(model_t s, logic [5:0] req, logic [5:0] audio,
                                        logic tick, logic dismiss, logic mute_all);
      model_t     n = s;
      logic [5:0] elig = req & ~s.muted;
      bit         found = 0;
      bit         higherWaiting = 0;
      bit         muteCur = 0;
      if (s.mode == 0) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig[i]) begin
               found = 1; n.mode = 1; n.cur = i; n.ticks = 0;
            end
         end
      end else if (s.mode == 1) begin
         for (int j = 0; j < s.cur; j++) if (elig[j]) higherWaiting = 1;
         if (!req[s.cur]) begin
            n.mode = 2;
         end else if (dismiss) begin
            n.mode = 2; muteCur = 1;
         end else if (tick && (s.ticks + 1 >= MAX_RING)) begin
            n.mode = 2; muteCur = 1;
         end else if (higherWaiting && (s.ticks >= MIN_HOLD)) begin
            n.mode = 2;
         end else if (tick) begin
            n.ticks = s.ticks + 1;
         end
         if (n.mode == 2) n.gap = 0;
      end else begin
         n.gap = s.gap + 1;
         if (n.gap == GAP_CYC) n.mode = 0;
      end
      n.muted = req & (s.muted | (muteCur ? (6'b000001 << s.cur) : 6'b000000));
      n.spk   = (n.mode == 1) ? (audio[n.cur] & ~mute_all) : 1'b0;
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) m <= modelReset();
      else      m <= modelNext(m, bus.req, bus.audio, bus.tick, bus.dismiss, bus.mute_all);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [5:0] expGrant;
      expGrant = (m.mode == 1) ? (6'b000001 << m.cur) : 6'b000000;
      checkOutput("mdl_grant",   32'(bus.grant),      32'(expGrant));
      checkOutput("mdl_idx",     32'(bus.active_idx), (m.mode == 1) ? m.cur : 0);
      checkOutput("mdl_busy",    32'(bus.busy),       32'(m.mode != 0));
      checkOutput("mdl_muted",   32'(bus.muted),      32'(m.muted));
      checkOutput("mdl_speaker", 32'(bus.speaker),    32'(m.spk));
   end

   // Pseudo-random tones change shortly after each edge; audio_prev is what the last edge sampled.
   initial begin
      bus.audio = 6'b100101;
      forever begin
         @(posedge clk);
         #2;
         audio_prev = bus.audio;
         bus.audio  = {bus.audio[4:0], bus.audio[5] ^ bus.audio[4]};
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not end, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [5:0] req, input logic tick,
                                input logic dismiss, input logic mute_all);
      bus.req      = req;
      bus.tick     = tick;
      bus.dismiss  = dismiss;
      bus.mute_all = mute_all;
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b0;
      bus.req      = '0;
      bus.tick     = 1'b0;
      bus.dismiss  = 1'b0;
      bus.mute_all = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_grant",   32'(bus.grant),   0);
      checkOutput("rst_busy",    32'(bus.busy),    0);
      checkOutput("rst_speaker", 32'(bus.speaker), 0);
      rst = 1'b1;

      $display("[TB] scenario 1: single request, drop, gap");
      applyStimulus(6'b000010, 0, 0, 0);
      checkOutput("t1_grant", 32'(bus.grant), 32'h02);
      checkOutput("t1_idx",   32'(bus.active_idx), 1);
      checkOutput("t1_busy",  32'(bus.busy), 1);
      checkOutput("t1_spk_a", 32'(bus.speaker), 32'(audio_prev[1]));
      applyStimulus(6'b000010, 0, 0, 0);
      checkOutput("t1_spk_b", 32'(bus.speaker), 32'(audio_prev[1]));
      applyStimulus(6'b000000, 0, 0, 0);
      checkOutput("t1_drop_grant", 32'(bus.grant), 0);
      checkOutput("t1_drop_spk",   32'(bus.speaker), 0);
      checkOutput("t1_drop_busy",  32'(bus.busy), 1);
      for (int k = 0; k < GAP_CYC - 1; k++) begin
         applyStimulus(6'b000000, 0, 0, 0);
         checkOutput("t1_gap_busy", 32'(bus.busy), 1);
      end
      applyStimulus(6'b000000, 0, 0, 0);
      checkOutput("t1_idle_busy", 32'(bus.busy), 0);

      $display("[TB] scenario 2: preemption after minimum hold");
      applyStimulus(6'b001000, 0, 0, 0);
      checkOutput("t2_grant3", 32'(bus.grant), 32'h08);
      applyStimulus(6'b001001, 1, 0, 0);
      checkOutput("t2_hold_a", 32'(bus.grant), 32'h08);
      applyStimulus(6'b001001, 0, 0, 0);
      checkOutput("t2_hold_b", 32'(bus.grant), 32'h08);
      applyStimulus(6'b001001, 1, 0, 0);
      checkOutput("t2_hold_c", 32'(bus.grant), 32'h08);
      applyStimulus(6'b001001, 0, 0, 0);
      checkOutput("t2_pre_grant", 32'(bus.grant), 0);
      checkOutput("t2_pre_muted", 32'(bus.muted), 0);
      repeat (GAP_CYC) applyStimulus(6'b001001, 0, 0, 0);
      checkOutput("t2_idle_grant", 32'(bus.grant), 0);
      applyStimulus(6'b001001, 0, 0, 0);
      checkOutput("t2_grant0", 32'(bus.grant), 32'h01);
      checkOutput("t2_idx0",   32'(bus.active_idx), 0);
      applyStimulus(6'b001000, 0, 0, 0);
      checkOutput("t2_drop0", 32'(bus.grant), 0);
      repeat (GAP_CYC) applyStimulus(6'b001000, 0, 0, 0);
      applyStimulus(6'b001000, 0, 0, 0);
      checkOutput("t2_regrant3", 32'(bus.grant), 32'h08);
      checkOutput("t2_idx3",     32'(bus.active_idx), 3);
      repeat (GAP_CYC + 1) applyStimulus(6'b000000, 0, 0, 0);
      checkOutput("t2_end_busy", 32'(bus.busy), 0);

      $display("[TB] scenario 3: dismiss and unmute on request drop");
      applyStimulus(6'b000100, 0, 0, 0);
      checkOutput("t3_grant2", 32'(bus.grant), 32'h04);
      applyStimulus(6'b000100, 0, 1, 0);
      checkOutput("t3_dis_muted", 32'(bus.muted), 32'h04);
      checkOutput("t3_dis_grant", 32'(bus.grant), 0);
      repeat (GAP_CYC + 1) applyStimulus(6'b000100, 0, 0, 0);
      checkOutput("t3_idle_grant", 32'(bus.grant), 0);
      checkOutput("t3_idle_busy",  32'(bus.busy), 0);
      checkOutput("t3_idle_muted", 32'(bus.muted), 32'h04);
      applyStimulus(6'b000000, 0, 0, 0);
      checkOutput("t3_unmute", 32'(bus.muted), 0);
      applyStimulus(6'b000100, 0, 0, 0);
      checkOutput("t3_regrant", 32'(bus.grant), 32'h04);
      repeat (GAP_CYC + 1) applyStimulus(6'b000000, 0, 0, 0);

      $display("[TB] scenario 4: ring timeout");
      applyStimulus(6'b100000, 0, 0, 0);
      checkOutput("t4_grant5", 32'(bus.grant), 32'h20);
      checkOutput("t4_idx5",   32'(bus.active_idx), 5);
      for (int k = 0; k < MAX_RING - 1; k++) begin
         applyStimulus(6'b100000, 1, 0, 0);
         applyStimulus(6'b100000, 0, 0, 0);
      end
      checkOutput("t4_before_to", 32'(bus.grant), 32'h20);
      applyStimulus(6'b100000, 1, 0, 0);
      checkOutput("t4_to_grant", 32'(bus.grant), 0);
      checkOutput("t4_to_muted", 32'(bus.muted), 32'h20);
      repeat (8) applyStimulus(6'b100000, 0, 0, 0);
      checkOutput("t4_no_regrant", 32'(bus.grant), 0);
      checkOutput("t4_idle_busy",  32'(bus.busy), 0);
      applyStimulus(6'b000000, 0, 0, 0);
      checkOutput("t4_unmute", 32'(bus.muted), 0);

      $display("[TB] scenario 5: mute_all during ring");
      applyStimulus(6'b010000, 0, 0, 1);
      checkOutput("t5_grant4", 32'(bus.grant), 32'h10);
      for (int k = 0; k < MAX_RING - 1; k++) begin
         applyStimulus(6'b010000, 1, 0, 1);
         checkOutput("t5_silent", 32'(bus.speaker), 0);
         applyStimulus(6'b010000, 0, 0, 1);
         checkOutput("t5_held", 32'(bus.grant), 32'h10);
      end
      applyStimulus(6'b010000, 1, 0, 1);
      checkOutput("t5_to_grant", 32'(bus.grant), 0);
      checkOutput("t5_to_muted", 32'(bus.muted), 32'h10);
      applyStimulus(6'b000000, 0, 0, 0);
      repeat (GAP_CYC) applyStimulus(6'b000000, 0, 0, 0);

      $display("[TB] scenario 6: asynchronous reset mid-ring");
      applyStimulus(6'b000100, 0, 0, 0);
      applyStimulus(6'b000100, 0, 1, 0);
      repeat (GAP_CYC + 1) applyStimulus(6'b000110, 0, 0, 0);
      checkOutput("t6_grant1", 32'(bus.grant), 32'h02);
      checkOutput("t6_muted2", 32'(bus.muted), 32'h04);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("t6_rst_grant",   32'(bus.grant),   0);
      checkOutput("t6_rst_speaker", 32'(bus.speaker), 0);
      checkOutput("t6_rst_muted",   32'(bus.muted),   0);
      checkOutput("t6_rst_idx",     32'(bus.active_idx), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6_rel_grant", 32'(bus.grant), 32'h02);
      checkOutput("t6_rel_idx",   32'(bus.active_idx), 1);
      repeat (GAP_CYC + 2) applyStimulus(6'b000000, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
